// File: rtl/mmio_bus_arbiter.sv
// mmio_bus_arbiter: shares one FPro MMIO bus between two masters.
// m0 is the CPU bridge and m1 is an auxiliary hardware sequencer.
// Each granted access becomes exactly one bus cycle (ISSUE). A one-cycle
// acknowledge with the captured read data follows in RESP.
// Accesses by m1 outside its slot window are rejected and never reach the bus.
module mmio_bus_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int M1_SLOT_LO = 12,
  parameter int M1_SLOT_HI = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req_i,
  input  logic        m0_wr_i,
  input  logic [20:0] m0_addr_i,
  input  logic [31:0] m0_wr_data_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_rd_data_o,
  input  logic        m1_req_i,
  input  logic        m1_wr_i,
  input  logic [20:0] m1_addr_i,
  input  logic [31:0] m1_wr_data_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_rd_data_o,
  output logic        m1_err_o,
  output logic        mmio_cs_o,
  output logic        mmio_wr_o,
  output logic        mmio_rd_o,
  output logic [20:0] mmio_addr_o,
  output logic [31:0] mmio_wr_data_o,
  input  logic [31:0] mmio_rd_data_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic [5:0] SLOT_LO = 6'(M1_SLOT_LO);
  localparam logic [5:0] SLOT_HI = 6'(M1_SLOT_HI);

  state_t      state_q;
  logic        last_grant_q;   // 1: m1 was granted most recently
  logic        grant_m1_q;
  logic        txn_wr_q;
  logic        reject_q;
  logic        m0_ack_q, m1_ack_q, m1_err_q;
  logic [31:0] m0_rd_data_q, m1_rd_data_q;
  logic        mmio_cs_q, mmio_wr_q, mmio_rd_q;
  logic [20:0] mmio_addr_q;
  logic [31:0] mmio_wr_data_q;

  logic        grant_vld_d;
  logic        grant_m1_d;
  logic        reject_d;
  logic        sel_wr_d;
  logic [20:0] sel_addr_d;
  logic [31:0] sel_wr_data_d;
  logic [5:0]  m1_slot_d;
  logic [31:0] rd_capture_d;

  // Pick the winner among pending requests and pre-compute the m1 window check
  always_comb begin
    grant_vld_d   = 1'b0;
    grant_m1_d    = 1'b0;
    m1_slot_d     = m1_addr_i[10:5];
    if (m0_req_i && m1_req_i) begin
      grant_vld_d = 1'b1;
      if (FIXED_PRIO != 0) begin
        grant_m1_d = 1'b0;
      end else begin
        grant_m1_d = ~last_grant_q;
      end
    end else if (m0_req_i) begin
      grant_vld_d = 1'b1;
      grant_m1_d  = 1'b0;
    end else if (m1_req_i) begin
      grant_vld_d = 1'b1;
      grant_m1_d  = 1'b1;
    end else begin
      grant_vld_d = 1'b0;
      grant_m1_d  = 1'b0;
    end
    reject_d      = grant_m1_d && ((m1_slot_d < SLOT_LO) || (m1_slot_d > SLOT_HI));
    sel_wr_d      = grant_m1_d ? m1_wr_i      : m0_wr_i;
    sel_addr_d    = grant_m1_d ? m1_addr_i    : m0_addr_i;
    sel_wr_data_d = grant_m1_d ? m1_wr_data_i : m0_wr_data_i;
    // Rejected accesses and writes return zero; only a real read samples the bus
    if (!reject_q && !txn_wr_q) begin
      rd_capture_d = mmio_rd_data_i;
    end else begin
      rd_capture_d = 32'h0000_0000;
    end
  end

  // Arbiter FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      last_grant_q   <= 1'b1;
      grant_m1_q     <= 1'b0;
      txn_wr_q       <= 1'b0;
      reject_q       <= 1'b0;
      m0_ack_q       <= 1'b0;
      m1_ack_q       <= 1'b0;
      m1_err_q       <= 1'b0;
      m0_rd_data_q   <= 32'h0000_0000;
      m1_rd_data_q   <= 32'h0000_0000;
      mmio_cs_q      <= 1'b0;
      mmio_wr_q      <= 1'b0;
      mmio_rd_q      <= 1'b0;
      mmio_addr_q    <= 21'h00_0000;
      mmio_wr_data_q <= 32'h0000_0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
          m1_err_q <= 1'b0;
          if (grant_vld_d) begin
            grant_m1_q   <= grant_m1_d;
            last_grant_q <= grant_m1_d;
            txn_wr_q     <= sel_wr_d;
            reject_q     <= reject_d;
            mmio_cs_q    <= ~reject_d;
            mmio_wr_q    <= ~reject_d & sel_wr_d;
            mmio_rd_q    <= ~reject_d & ~sel_wr_d;
            if (!reject_d) begin
              mmio_addr_q    <= sel_addr_d;
              mmio_wr_data_q <= sel_wr_data_d;
            end
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mmio_cs_q <= 1'b0;
          mmio_wr_q <= 1'b0;
          mmio_rd_q <= 1'b0;
          if (grant_m1_q) begin
            m1_ack_q     <= 1'b1;
            m1_err_q     <= reject_q;
            m1_rd_data_q <= rd_capture_d;
          end else begin
            m0_ack_q     <= 1'b1;
            m0_rd_data_q <= rd_capture_d;
          end
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
          m1_err_q <= 1'b0;
          reject_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          mmio_cs_q <= 1'b0;
          mmio_wr_q <= 1'b0;
          mmio_rd_q <= 1'b0;
          m0_ack_q  <= 1'b0;
          m1_ack_q  <= 1'b0;
          m1_err_q  <= 1'b0;
          reject_q  <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign m0_ack_o       = m0_ack_q;
  assign m1_ack_o       = m1_ack_q;
  assign m1_err_o       = m1_err_q;
  assign m0_rd_data_o   = m0_rd_data_q;
  assign m1_rd_data_o   = m1_rd_data_q;
  assign mmio_cs_o      = mmio_cs_q;
  assign mmio_wr_o      = mmio_wr_q;
  assign mmio_rd_o      = mmio_rd_q;
  assign mmio_addr_o    = mmio_addr_q;
  assign mmio_wr_data_o = mmio_wr_data_q;

endmodule

// File: doc/mmio_bus_arbiter.md
# mmio_bus_arbiter

Two-master arbiter in front of `chu_mmio_controller` that shares the single FPro MMIO bus between the CPU bridge (m0) and an auxiliary hardware sequencer (m1), e.g. an autonomous DDFS/ADSR note player.
- Each access is serialized into exactly one bus cycle, with the read data captured and returned alongside a one-cycle acknowledge.
- Supports round-robin or fixed-priority arbitration.
- m1 can be restricted to a window of I/O slots; a violating access is rejected without touching the bus.

## Interface
Parameters:
- `FIXED_PRIO`, default 0: 0 selects round-robin; 1 means m0 always wins a tie.
- `M1_SLOT_LO`, default 12: lowest slot number (`addr[10:5]`) m1 may access.
- `M1_SLOT_HI`, default 13: highest slot number m1 may access.

Ports (direction, width, meaning):
- `clk`, in, 1: system clock. This block has one clock domain.
- `reset`, in, 1: reset is synchronous and active-high.
- `m0_req`, `m1_req`, in, 1 each: request. Held high, with the request fields stable, until the matching ack.
- `m0_wr`, `m1_wr`, in, 1 each: 1 means write, 0 means read.
- `m0_addr`, `m1_addr`, in, 21 each: MMIO address.
- `m0_wr_data`, `m1_wr_data`, in, 32 each: write data.
- `m0_ack`, `m1_ack`, out, 1 each: one-cycle completion pulse.
- `m0_rd_data`, `m1_rd_data`, out, 32 each: read data, valid while the matching ack is high, and held until the next ack to that master.
- `m1_err`, out, 1: high with `m1_ack` when m1's address is outside the allowed slot window.
- `mmio_cs`, `mmio_wr`, `mmio_rd`, out, 1 each: FPro bus strobes toward the controller.
- `mmio_addr`, out, 21: FPro bus address.
- `mmio_wr_data`, out, 32: FPro bus write data.
- `mmio_rd_data`, in, 32: FPro bus read data. Combinational from the controller and valid in the strobe cycle.

## Operation
FSM states: IDLE, ISSUE, RESP.

IDLE:
- If neither `req` is high, stay in IDLE.
- If exactly one `req` is high, grant that master.
- If both are high:
  - with `FIXED_PRIO`=1, grant m0;
  - otherwise, grant the master that was not granted most recently.
- On a grant, register the winner's `wr`, `addr` and `wr_data` into the transaction registers, update `last_grant`, and go to ISSUE.
- m1 window check, done in IDLE: `slot = m1_addr[10:5]`. If `slot < M1_SLOT_LO` or `slot > M1_SLOT_HI`, set an internal `reject` flag.

ISSUE:
- If `reject` is clear:
  - drive `mmio_cs`=1 and `mmio_addr`/`mmio_wr_data` from the registers;
  - drive `mmio_wr`=`wr` and `mmio_rd`=!`wr`;
  - capture `mmio_rd_data` at the clock edge on a read;
  - `mmio_rd_data` is not sampled on a write.
- If `reject` is set, all bus strobes stay 0 and the captured data is 0.
- Always go to RESP.

RESP:
- Pulse the granted master's `ack` for one cycle and present its `rd_data`.
- Assert `m1_err` = `reject` when the grant is m1.
- Clear `reject` and go to IDLE.

General rules:
- Requests are never sampled in ISSUE or RESP. A `req` still high in the cycle after its ack is a new request.
- Only one transaction is outstanding at a time. A request from the non-granted master waits, and its fields are not sampled until it is granted.
- Bus strobes are high only in ISSUE, for exactly one cycle per accepted transaction. `mmio_addr`/`mmio_wr_data` may hold the last values outside ISSUE, but `mmio_cs` must be 0.

## Timing
Reset values:
- All outputs are 0: strobes, `mmio_addr`, `mmio_wr_data`, both acks, both `rd_data`, `m1_err`.
- The FSM is in IDLE.
- `last_grant` = m1, so m0 wins the first tie.

Latency and throughput:
- `req` sampled high in cycle T (IDLE) → bus strobe in T+1 → `ack` in T+2.
- A master holding `req` continuously gets one transaction per 3 cycles.
- Under round-robin with both masters requesting continuously, grants alternate m0, m1, m0, …; each master gets one transaction per 6 cycles.

Reset mid-operation:
- Reset in ISSUE or RESP aborts the transaction: no ack is issued and strobes drop on the next cycle.
- Masters must reissue.

Write ordering: a read issued after a write acknowledged by the same master observes that write.

## Test plan
- **Reset.** Assert reset for 2 cycles with both `req`=1 → all outputs are 0 during reset. First grant after release goes to m0: `mmio_cs` high at T+1, `m0_ack` at T+2.
- **m0 read.** m0 reads addr `0x000060` (slot 3); the bench drives `mmio_rd_data`=`0x000000A5` in the strobe cycle → `mmio_rd`=1 and `mmio_wr`=0 for one cycle; `m0_ack`=1 with `m0_rd_data`=`0xA5` exactly 2 cycles after the request.
- **Round-robin contention.** `FIXED_PRIO`=0; both masters hold `req` for 12 cycles → grant order m0, m1, m0, m1. Acks arrive at cycles 2, 5, 8, 11; never two acks in the same cycle.
- **Fixed priority.** `FIXED_PRIO`=1 with the same stimulus → m0 is acked at 2, 5, 8, 11; m1 gets no ack until m0 drops `req`.
- **m1 protection.** m1 writes `0x000020` (slot 1) → no strobe is ever asserted; `m1_ack`=1, `m1_err`=1, `m1_rd_data`=0. An m1 write to slot 12 with data `0x12345678` → one `mmio_wr` cycle with that data, `m1_err`=0.
- **Reset mid-transaction.** Assert reset in the ISSUE cycle of an m1 write → no `m1_ack` is issued and `mmio_cs`=0 the next cycle. After release, a held m0 request completes normally at T+2.
